// File: rtl/pwm_audio_output.sv
// PWM audio output stage: a small sample FIFO feeding a glitch-free, period-synchronous PWM.
// Optional build macro PWM_VOLUME_EN adds a 3-bit volume input that attenuates each popped sample.
module pwm_audio_output #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          inputClock,
  input  logic                          reset_n,
  input  logic                          enable,
`ifdef PWM_VOLUME_EN
  input  logic [2:0]                    volume,
`endif
  input  logic [SAMPLE_WIDTH-1:0]       inputSample,
  input  logic                          sampleValid,
  output logic                          sampleReady,
  output logic                          pwmOut,
  output logic                          periodStart,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [SAMPLE_WIDTH-1:0] CNT_ZERO = {SAMPLE_WIDTH{1'b0}};
  localparam logic [SAMPLE_WIDTH-1:0] CNT_ONE  = SAMPLE_WIDTH'(1'b1);
  localparam logic [SAMPLE_WIDTH-1:0] MID      = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
  localparam logic [PTR_W-1:0]        PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]        PTR_ONE  = PTR_W'(1'b1);
  localparam logic [PTR_W:0]          LVL_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]          LVL_ONE  = (PTR_W+1)'(1'b1);
  localparam logic [PTR_W:0]          LVL_FULL = (PTR_W+1)'(FIFO_DEPTH);

  logic [SAMPLE_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [PTR_W:0]          level_r;
  logic [SAMPLE_WIDTH-1:0] counter_r;
  logic [SAMPLE_WIDTH-1:0] duty_r;
  logic                    pwm_r;
  logic                    period_start_r;
  logic                    underrun_r;

  logic                    full_s;
  logic                    push_s;
  logic                    load_s;
  logic                    pop_s;
  logic [SAMPLE_WIDTH-1:0] head_s;
  logic [SAMPLE_WIDTH-1:0] loaded_s;
  logic [SAMPLE_WIDTH-1:0] duty_eff_s;
  logic                    pwm_next_s;

`ifdef PWM_VOLUME_EN
  // Offset-binary to two's complement is a flip of the MSB; shift arithmetically, then flip back.
  function automatic logic [SAMPLE_WIDTH-1:0] scale_sample(
    input logic [SAMPLE_WIDTH-1:0] sample,
    input logic [2:0]              vol
  );
    logic signed [SAMPLE_WIDTH-1:0] centred;
    centred = $signed(sample ^ MID);
    return $unsigned(centred >>> vol) ^ MID;
  endfunction
`endif

  // Handshake, load-cycle decode and next-duty selection.
  always_comb begin
    full_s = (level_r == LVL_FULL);
    push_s = sampleValid && !full_s;
    load_s = enable && (counter_r == CNT_ZERO);
    pop_s  = load_s && (level_r != LVL_ZERO);
    head_s = mem_r[rd_ptr_r];
`ifdef PWM_VOLUME_EN
    loaded_s = scale_sample(head_s, volume);
`else
    loaded_s = head_s;
`endif
    if (pop_s) begin
      duty_eff_s = loaded_s;
    end else begin
      duty_eff_s = duty_r;
    end
    if (enable) begin
      pwm_next_s = (counter_r < duty_eff_s);
    end else begin
      pwm_next_s = 1'b0;
    end
  end

  // Sample storage; stale entries are harmless because the pointers define occupancy.
  always_ff @(posedge inputClock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= inputSample;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // PWM counter, duty register and registered status outputs.
  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      counter_r      <= CNT_ZERO;
      duty_r         <= CNT_ZERO;
      pwm_r          <= 1'b0;
      period_start_r <= 1'b0;
      underrun_r     <= 1'b0;
    end else begin
      if (enable) begin
        counter_r <= counter_r + CNT_ONE;
      end else begin
        counter_r <= CNT_ZERO;
      end
      duty_r         <= duty_eff_s;
      pwm_r          <= pwm_next_s;
      period_start_r <= load_s;
      underrun_r     <= load_s && !pop_s;
    end
  end

  assign sampleReady = !full_s;
  assign pwmOut      = pwm_r;
  assign periodStart = period_start_r;
  assign underrun    = underrun_r;
  assign fifoLevel   = level_r;

endmodule

// File: tb/tb_pwm_audio_output.sv
// Self-checking bench for pwm_audio_output: vector table for FIFO fill, scoreboard of per-period expectations.
module tb_pwm_audio_output;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] inputSample;
  logic       sampleValid;
  logic       sampleReady;
  logic       pwmOut;
  logic       periodStart;
  logic       underrun;
  logic [2:0] fifoLevel;
`ifdef PWM_VOLUME_EN
  logic [2:0] volume;
`endif

  typedef struct {
    logic [7:0] sample;
    int         high;
  } vec_t;

  typedef struct {
    int high;
    int und;
    int level;
  } exp_t;

  vec_t tbl[4];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  pwm_audio_output #(.SAMPLE_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .inputClock (clk),
    .reset_n    (reset_n),
    .enable     (enable),
`ifdef PWM_VOLUME_EN
    .volume     (volume),
`endif
    .inputSample(inputSample),
    .sampleValid(sampleValid),
    .sampleReady(sampleReady),
    .pwmOut     (pwmOut),
    .periodStart(periodStart),
    .underrun   (underrun),
    .fifoLevel  (fifoLevel)
  );

  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  task automatic push_sample(input logic [7:0] s);
    sampleValid = 1'b1;
    inputSample = s;
    @(negedge clk);
    sampleValid = 1'b0;
  endtask

  task automatic expect_period(input int high, input int und, input int level);
    exp_t e;
    e.high  = high;
    e.und   = und;
    e.level = level;
    exp_q.push_back(e);
  endtask

  task automatic wait_start(input string nm);
    int w = 0;
    while (!periodStart && w < 600) begin
      @(negedge clk);
      w++;
    end
    check({nm, "_start"}, int'(periodStart), 1);
  endtask

  // One full period: 256 pwmOut samples starting at the periodStart pulse.
  task automatic run_period(input string nm);
    exp_t e;
    int   cnt;
    int   ps_in;
    int   und_in;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s_scoreboard: got empty queue, expected an entry", nm);
      return;
    end
    e = exp_q.pop_front();
    wait_start(nm);
    check({nm, "_underrun"}, int'(underrun), e.und);
    check({nm, "_level"}, int'(fifoLevel), e.level);
    check({nm, "_ready"}, int'(sampleReady), (e.level != 4) ? 1 : 0);
    cnt    = int'(pwmOut);
    ps_in  = 0;
    und_in = 0;
    for (int i = 1; i < 256; i++) begin
      @(negedge clk);
      cnt    += int'(pwmOut);
      ps_in  += int'(periodStart);
      und_in += int'(underrun);
    end
    check({nm, "_high"}, cnt, e.high);
    check({nm, "_ps_inside"}, ps_in, 0);
    check({nm, "_und_inside"}, und_in, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    tbl[0] = '{8'h80, 128};
    tbl[1] = '{8'h40, 64};
    tbl[2] = '{8'hFF, 255};
    tbl[3] = '{8'h00, 0};

    reset_n     = 1'b0;
    enable      = 1'b0;
    sampleValid = 1'b0;
    inputSample = 8'h00;
`ifdef PWM_VOLUME_EN
    volume      = 3'd0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst_pwm", int'(pwmOut), 0);
    check("rst_ps", int'(periodStart), 0);
    check("rst_und", int'(underrun), 0);
    check("rst_level", int'(fifoLevel), 0);
    check("rst_ready", int'(sampleReady), 1);
    reset_n = 1'b1;

    // Empty FIFO: three underrun periods, output stays low.
    enable = 1'b1;
    for (int i = 0; i < 3; i++) expect_period(0, 1, 0);
    for (int i = 0; i < 3; i++) run_period("empty");

    // Fill from the table while disabled.
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_sample(tbl[i].sample);
      check("fill_level", int'(fifoLevel), i + 1);
      check("fill_ready", int'(sampleReady), (i < 3) ? 1 : 0);
      expect_period(tbl[i].high, 0, 3 - i);
    end

    // Pushing while full stores nothing.
    sampleValid = 1'b1;
    inputSample = 8'h11;
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("full_level", int'(fifoLevel), 4);
    check("full_ready", int'(sampleReady), 0);
    sampleValid = 1'b0;

    enable = 1'b1;
    for (int i = 0; i < 4; i++) run_period("table");

    // Push on the same edge as a load cycle with an empty FIFO.
    sampleValid = 1'b1;
    inputSample = 8'hC0;
    expect_period(0, 1, 1);
    expect_period(192, 0, 0);
    @(negedge clk);
    sampleValid = 1'b0;
    run_period("sim_push");
    run_period("after_push");

    // Mid-period disable and re-enable.
    enable = 1'b0;
    @(negedge clk);
    check("dis_ps", int'(periodStart), 0);
    check("dis_und", int'(underrun), 0);
    push_sample(8'h60);
    push_sample(8'h20);
    check("dis_level", int'(fifoLevel), 2);
    enable = 1'b1;
    wait_start("partial");
    check("partial_und", int'(underrun), 0);
    check("partial_level", int'(fifoLevel), 1);
    cnt = int'(pwmOut);
    for (int i = 1; i < 100; i++) begin
      @(negedge clk);
      cnt += int'(pwmOut);
    end
    check("partial_high", cnt, 96);
    enable = 1'b0;
    push_sample(8'hE0);
    check("dis_push_level", int'(fifoLevel), 2);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cnt += int'(pwmOut) + int'(periodStart) + int'(underrun);
      @(negedge clk);
    end
    check("dis_quiet", cnt, 0);
    expect_period(32, 0, 1);
    expect_period(224, 0, 0);
    enable = 1'b1;
    run_period("reenable");
    run_period("reenable2");

    // Asynchronous reset in the middle of a period.
    enable = 1'b0;
    push_sample(8'h90);
    push_sample(8'h91);
    check("pre_rst_level", int'(fifoLevel), 2);
    enable = 1'b1;
    wait_start("pre_rst");
    check("pre_rst_level2", int'(fifoLevel), 1);
    for (int i = 0; i < 50; i++) @(negedge clk);
    check("pre_rst_pwm", int'(pwmOut), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_pwm", int'(pwmOut), 0);
    check("mid_rst_ps", int'(periodStart), 0);
    check("mid_rst_und", int'(underrun), 0);
    check("mid_rst_level", int'(fifoLevel), 0);
    check("mid_rst_ready", int'(sampleReady), 1);
    @(negedge clk);
    reset_n = 1'b1;
    expect_period(0, 1, 0);
    run_period("post_rst");

`ifdef PWM_VOLUME_EN
    // Volume attenuation applied at pop time.
    enable = 1'b0;
    volume = 3'd1;
    push_sample(8'hFF);
    push_sample(8'h00);
    push_sample(8'hFF);
    expect_period(191, 0, 2);
    expect_period(64, 0, 1);
    expect_period(128, 0, 0);
    enable = 1'b1;
    run_period("vol1_ff");
    run_period("vol1_00");
    volume = 3'd7;
    run_period("vol7_ff");
`endif

    enable = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
